updown_counter: RTL and testbench

Parametrised up/down counter with programmable bounds, step size and four run modes: up-wrap, down-wrap, bounce and one-shot. It replaces fixed-width, fixed-range up/down bouncing counters wherever a design needs a sequenced address, a PWM ramp or a timeout. Terminal events come out as a registered single-cycle pulse. Direction and completion are visible to downstream control.

---
 rtl/updown_pkg.sv | 24 ++
 rtl/updown_step.sv | 36 +++
 rtl/updown_counter.sv | 143 ++++++++++++++
 tb/tb_updown_counter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter slice.
package updown_pkg;

  // Run modes, encoded to match the 2-bit mode input.
  typedef enum logic [1:0] {
    UP_WRAP   = 2'd0,
    DOWN_WRAP = 2'd1,
    BOUNCE    = 2'd2,
    ONE_SHOT  = 2'd3
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Direction a mode imposes; BOUNCE keeps whatever direction it already had.
  function automatic logic mode_dir(input mode_t m, input logic cur_dir);
    case (m)
      DOWN_WRAP: mode_dir = DIR_DOWN;
      BOUNCE:    mode_dir = cur_dir;
      default:   mode_dir = DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/updown_step.sv
// Combinational step datapath: saturating next-up / next-down values and
// position flags for the current count against the programmed bounds.
module updown_step
  import updown_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] up_next,
  output logic [WIDTH-1:0] dn_next,
  output logic             at_hi,
  output logic             at_lo,
  output logic             in_range
);

  // One extra bit so neither the sum nor the difference can wrap through 0 or 2^WIDTH-1.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, out} + {1'b0, step};
  assign dif = {1'b0, out} - {1'b0, step};

  // Saturate at the bounds; a set top bit in dif means the difference went negative.
  always_comb begin
    up_next = (sum > {1'b0, hi}) ? hi : sum[WIDTH-1:0];
    dn_next = (dif[WIDTH] || (dif[WIDTH-1:0] < lo)) ? lo : dif[WIDTH-1:0];
  end

  assign at_hi    = (out == hi);
  assign at_lo    = (out == lo);
  assign in_range = (out >= lo) && (out <= hi);

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable bounds and step, four run modes,
// a registered terminal-count pulse and a sticky one-shot done flag.
module updown_counter
  import updown_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             tc,
  output logic             done,
  output logic             cfg_err
);

  mode_t            mode_e;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic             at_hi;
  logic             at_lo;
  logic             in_range;
  logic [WIDTH-1:0] load_clamped;

  logic [WIDTH-1:0] out_d;
  logic             dir_d;
  logic             tc_d;
  logic             done_d;

  assign mode_e  = mode_t'(mode);
  assign cfg_err = (lo > hi);

  updown_step #(.WIDTH(WIDTH)) u_step (
    .out      (out),
    .step     (step),
    .lo       (lo),
    .hi       (hi),
    .up_next  (up_next),
    .dn_next  (dn_next),
    .at_hi    (at_hi),
    .at_lo    (at_lo),
    .in_range (in_range)
  );

  // Loaded values are clamped into the current window.
  always_comb begin
    if (load_val < lo)      load_clamped = lo;
    else if (load_val > hi) load_clamped = hi;
    else                    load_clamped = load_val;
  end

  // Next-state: load, then config-error hold, enable, out-of-range recovery, then mode stepping.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    out_d  = out;
    dir_d  = dir;
    done_d = done;
    tc_d   = 1'b0;

    if (load) begin
      out_d  = load_clamped;
      dir_d  = (mode_e == DOWN_WRAP) ? DIR_DOWN : DIR_UP;
      done_d = 1'b0;
    end else if (cfg_err || !en) begin
      // hold everything; tc already defaults low
    end else if (!in_range) begin
      out_d = lo;
      dir_d = DIR_UP;
    end else if (step == '0) begin
      dir_d = mode_dir(mode_e, dir);
    end else begin
      case (mode_e)
        UP_WRAP: begin
          dir_d = DIR_UP;
          if (at_hi) begin
            out_d = lo;
            tc_d  = 1'b1;
          end else begin
            out_d = up_next;
          end
        end
        DOWN_WRAP: begin
          dir_d = DIR_DOWN;
          if (at_lo) begin
            out_d = hi;
            tc_d  = 1'b1;
          end else begin
            out_d = dn_next;
          end
        end
        BOUNCE: begin
          if (dir == DIR_UP) begin
            out_d = up_next;
            if (up_next == hi) begin
              dir_d = DIR_DOWN;
              tc_d  = 1'b1;
            end
          end else begin
            out_d = dn_next;
            if (dn_next == lo) begin
              dir_d = DIR_UP;
              tc_d  = 1'b1;
            end
          end
        end
        default: begin
          dir_d = DIR_UP;
          if (!done) begin
            out_d = up_next;
            if (up_next == hi) begin
              done_d = 1'b1;
              tc_d   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      out  <= '0;
      dir  <= DIR_UP;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      out  <= out_d;
      dir  <= dir_d;
      tc   <= tc_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: a driver applies stimulus on the
// falling edge and pushes the reference model's expected state; a monitor
// pops and compares after every rising edge.
module tb_updown_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] lo = '0;
  logic [W-1:0] hi = '0;
  logic [W-1:0] step = '0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] out;
  logic         dir;
  logic         tc;
  logic         done;
  logic         cfg_err;

  typedef struct {
    int out;
    int dir;
    int tc;
    int done;
    int cfg_err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state, plain integers
  int m_out = 0, m_dir = 0, m_tc = 0, m_done = 0;

  updown_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .step     (step),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .dir      (dir),
    .tc       (tc),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model: what one rising edge should do to the counter state.
  task automatic model(input int r, input int e, input int m, input int l, input int h,
                       input int s, input int ld, input int lv);
    int up, dn;
    up = (m_out + s > h) ? h : m_out + s;
    dn = (m_out - s < l) ? l : m_out - s;
    if (r == 0) begin
      m_out = 0; m_dir = 0; m_tc = 0; m_done = 0;
    end else if (ld != 0) begin
      m_out  = (lv < l) ? l : ((lv > h) ? h : lv);
      m_dir  = (m == 1) ? 1 : 0;
      m_done = 0;
      m_tc   = 0;
    end else if (l > h || e == 0) begin
      m_tc = 0;
    end else if (m_out < l || m_out > h) begin
      m_out = l; m_dir = 0; m_tc = 0;
    end else if (s == 0) begin
      m_tc = 0;
      if (m != 2) m_dir = (m == 1) ? 1 : 0;
    end else begin
      m_tc = 0;
      case (m)
        0: begin
          m_dir = 0;
          if (m_out == h) begin m_out = l; m_tc = 1; end
          else m_out = up;
        end
        1: begin
          m_dir = 1;
          if (m_out == l) begin m_out = h; m_tc = 1; end
          else m_out = dn;
        end
        2: begin
          if (m_dir == 0) begin
            m_out = up;
            if (up == h) begin m_dir = 1; m_tc = 1; end
          end else begin
            m_out = dn;
            if (dn == l) begin m_dir = 0; m_tc = 1; end
          end
        end
        default: begin
          m_dir = 0;
          if (m_done == 0) begin
            m_out = up;
            if (up == h) begin m_done = 1; m_tc = 1; end
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge state.
  task automatic cyc(input int r, input int e, input int m, input int l, input int h,
                     input int s, input int ld, input int lv);
    exp_t x;
    @(negedge clk);
    rstn     = (r != 0);
    en       = (e != 0);
    mode     = m[1:0];
    lo       = l[W-1:0];
    hi       = h[W-1:0];
    step     = s[W-1:0];
    load     = (ld != 0);
    load_val = lv[W-1:0];
    model(r, e, m, l, h, s, ld, lv);
    x.out = m_out; x.dir = m_dir; x.tc = m_tc; x.done = m_done;
    x.cfg_err = (l > h) ? 1 : 0;
    q.push_back(x);
  endtask

  // Directed check against hand-derived constants, right after the edge just driven.
  task automatic check(input string name, input int e_out, input int e_dir,
                       input int e_tc, input int e_done, input int e_cfg);
    @(posedge clk);
    #1;
    tests++;
    if (int'(out) != e_out || int'(dir) != e_dir || int'(tc) != e_tc ||
        int'(done) != e_done || int'(cfg_err) != e_cfg) begin
      fails++;
      $display("FAIL %s: got out=%0d dir=%0d tc=%0d done=%0d cfg_err=%0d, want out=%0d dir=%0d tc=%0d done=%0d cfg_err=%0d",
               name, out, dir, tc, done, cfg_err, e_out, e_dir, e_tc, e_done, e_cfg);
    end
  endtask

  // Monitor: compare every edge's registered state against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        tests++;
        if (int'(out) != x.out || int'(dir) != x.dir || int'(tc) != x.tc ||
            int'(done) != x.done || int'(cfg_err) != x.cfg_err) begin
          fails++;
          $display("FAIL scoreboard @%0t: got out=%0d dir=%0d tc=%0d done=%0d cfg_err=%0d, want out=%0d dir=%0d tc=%0d done=%0d cfg_err=%0d",
                   $time, out, dir, tc, done, cfg_err, x.out, x.dir, x.tc, x.done, x.cfg_err);
        end
      end
    end
  end

  // Driver: directed scenarios followed by a randomized run.
  initial begin
    int l, h, s, m;

    // Reset then full-range BOUNCE
    cyc(0, 0, 2, 0, 255, 1, 0, 0);
    check("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 254; i++) cyc(1, 1, 2, 0, 255, 1, 0, 0);
    cyc(1, 1, 2, 0, 255, 1, 0, 0);
    check("bounce_top", 255, 1, 1, 0, 0);
    for (int i = 0; i < 254; i++) cyc(1, 1, 2, 0, 255, 1, 0, 0);
    cyc(1, 1, 2, 0, 255, 1, 0, 0);
    check("bounce_bottom", 0, 0, 1, 0, 0);
    cyc(1, 1, 2, 0, 255, 1, 0, 0);
    check("bounce_restart", 1, 0, 0, 0, 0);

    // UP_WRAP clamp and wrap
    cyc(1, 0, 0, 10, 20, 4, 1, 10);
    check("upwrap_load", 10, 0, 0, 0, 0);
    cyc(1, 1, 0, 10, 20, 4, 0, 0);
    check("upwrap_14", 14, 0, 0, 0, 0);
    cyc(1, 1, 0, 10, 20, 4, 0, 0);
    check("upwrap_18", 18, 0, 0, 0, 0);
    cyc(1, 1, 0, 10, 20, 4, 0, 0);
    check("upwrap_clamp20", 20, 0, 0, 0, 0);
    cyc(1, 1, 0, 10, 20, 4, 0, 0);
    check("upwrap_wrap10", 10, 0, 1, 0, 0);

    // Load wins over en, and is clamped to hi
    cyc(1, 1, 0, 10, 20, 4, 1, 30);
    check("load_clamp_hi", 20, 0, 0, 0, 0);

    // cfg_err freezes the counter
    cyc(1, 1, 0, 50, 40, 4, 0, 0);
    check("cfg_err_freeze", 20, 0, 0, 0, 1);
    cyc(1, 1, 0, 50, 40, 4, 0, 0);
    check("cfg_err_hold", 20, 0, 0, 0, 1);

    // DOWN_WRAP with out-of-range recovery after reset
    cyc(0, 1, 1, 5, 9, 1, 0, 0);
    check("dw_reset", 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 5, 9, 1, 0, 0);
    check("dw_recover", 5, 0, 0, 0, 0);
    cyc(1, 1, 1, 5, 9, 1, 0, 0);
    check("dw_wrap9", 9, 1, 1, 0, 0);
    cyc(1, 1, 1, 5, 9, 1, 0, 0);
    check("dw_8", 8, 1, 0, 0, 0);
    cyc(1, 1, 1, 5, 9, 1, 0, 0);
    check("dw_7", 7, 1, 0, 0, 0);

    // ONE_SHOT
    cyc(0, 0, 3, 0, 3, 1, 0, 0);
    cyc(1, 1, 3, 0, 3, 1, 0, 0);
    cyc(1, 1, 3, 0, 3, 1, 0, 0);
    cyc(1, 1, 3, 0, 3, 1, 0, 0);
    check("oneshot_done", 3, 0, 1, 1, 0);
    for (int i = 0; i < 9; i++) cyc(1, 1, 3, 0, 3, 1, 0, 0);
    cyc(1, 1, 3, 0, 3, 1, 0, 0);
    check("oneshot_hold", 3, 0, 0, 1, 0);
    cyc(1, 1, 3, 0, 3, 1, 1, 1);
    check("oneshot_reload", 1, 0, 0, 0, 0);

    // Reset mid-BOUNCE while counting down, then en low holds
    cyc(1, 1, 2, 0, 10, 3, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 2, 0, 10, 3, 0, 0);
    cyc(1, 1, 2, 0, 10, 3, 0, 0);
    check("bounce_down7", 7, 1, 0, 0, 0);
    cyc(0, 1, 2, 0, 10, 3, 1, 5);
    check("mid_reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2, 0, 10, 3, 0, 0);
      check("en_low_hold", 0, 0, 0, 0, 0);
    end

    // BOUNCE with lo == hi: dir toggles, tc stays high
    cyc(1, 1, 2, 6, 6, 1, 1, 6);
    cyc(1, 1, 2, 6, 6, 1, 0, 0);
    check("bounce_flat1", 6, 1, 1, 0, 0);
    cyc(1, 1, 2, 6, 6, 1, 0, 0);
    check("bounce_flat2", 6, 0, 1, 0, 0);

    // Randomized run, all checking done by the scoreboard
    l = 0; h = 30; s = 1; m = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        l = $urandom_range(0, 255);
        if ($urandom_range(0, 9) == 0) h = $urandom_range(0, 255);
        else h = l + $urandom_range(0, (255 - l < 40) ? 255 - l : 40);
      end
      if ($urandom_range(0, 29) == 0) m = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0)
        s = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      cyc(($urandom_range(0, 99) == 0) ? 0 : 1,
          ($urandom_range(0, 99) < 85) ? 1 : 0,
          m, l, h, s,
          ($urandom_range(0, 99) < 4) ? 1 : 0,
          $urandom_range(0, 255));
    end

    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
